// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode/funct constants and the fetch
// queue entry layout.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] ir;
    logic        is_branch;
    logic        is_jump;
    logic        is_jr;
  } fq_entry_t;

endpackage

// File: rtl/mips_predecode.sv
// Control-flow class of an instruction word (branch / jump / jump-register).
module mips_predecode
  import mips_pkg::*;
(
  input  logic [31:0] ir,
  output logic        is_branch,
  output logic        is_jump,
  output logic        is_jr
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  // Classify by opcode, plus funct for the R-type jr.
  always_comb begin
    is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    is_jump   = (opcode == OP_J)   || (opcode == OP_JAL);
    is_jr     = (opcode == OP_RTYPE) && (funct == FUNCT_JR);
  end

endmodule

// File: rtl/mips_fetch_queue.sv
// Instruction prefetch queue between fetch and decode, with enqueue-time
// predecode and single-cycle flush on redirect.
module mips_fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [29:0]      in_pc,
  input  logic [31:0]      in_ir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [29:0]      out_pc,
  output logic [31:0]      out_ir,
  output logic             out_is_branch,
  output logic             out_is_jump,
  output logic             out_is_jr,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  fq_entry_t        storage [DEPTH];
  fq_entry_t        in_entry;
  fq_entry_t        head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             pd_branch;
  logic             pd_jump;
  logic             pd_jr;

  mips_predecode u_predecode (
    .ir        (in_ir),
    .is_branch (pd_branch),
    .is_jump   (pd_jump),
    .is_jr     (pd_jr)
  );

  // Handshakes and entry assembly; in_ready ignores out_ready (no full bypass).
  always_comb begin
    in_ready  = (count != FULL_CNT);
    out_valid = (count != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    in_entry  = '{pc: in_pc, ir: in_ir, is_branch: pd_branch,
                  is_jump: pd_jump, is_jr: pd_jr};
  end

  // Head fields straight from storage; stale when empty.
  always_comb begin
    head          = storage[rd_ptr];
    out_pc        = head.pc;
    out_ir        = head.ir;
    out_is_branch = head.is_branch;
    out_is_jump   = head.is_jump;
    out_is_jr     = head.is_jr;
  end

  // Pointer and occupancy state; flush overrides any same-cycle push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset, written on an accepted, unflushed push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) storage[i] <= '0;
    end else if (push && !flush) begin
      storage[wr_ptr] <= in_entry;
    end
  end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: directed vector table, hand sequences for
// flush/async reset, and randomized traffic against a queue-based model.
module tb_mips_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] in_pc;
  logic [31:0] in_ir;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] out_pc;
  logic [31:0] out_ir;
  logic        out_is_branch;
  logic        out_is_jump;
  logic        out_is_jr;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  mips_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_ir         (in_ir),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_ir        (out_ir),
    .out_is_branch (out_is_branch),
    .out_is_jump   (out_is_jump),
    .out_is_jr     (out_is_jr),
    .count         (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [29:0] pc;
    logic [31:0] ir;
    logic        ordy;
    logic [2:0]  cnt;
    logic        ov;
    logic [29:0] opc;
    logic [31:0] oir;
    logic [2:0]  flg;
    logic        irdy;
  } vec_t;

  typedef struct {
    logic [29:0] pc;
    logic [31:0] ir;
  } mdl_t;

  vec_t vecs[$];
  mdl_t model_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic fl, input logic iv, input logic [29:0] pc,
                              input logic [31:0] ir, input logic ordy, input logic [2:0] cnt,
                              input logic ov, input logic [29:0] opc, input logic [31:0] oir,
                              input logic [2:0] flg, input logic irdy);
    vec_t v;
    v.fl = fl; v.iv = iv; v.pc = pc; v.ir = ir; v.ordy = ordy;
    v.cnt = cnt; v.ov = ov; v.opc = opc; v.oir = oir; v.flg = flg; v.irdy = irdy;
    vecs.push_back(v);
  endfunction

  // {branch, jump, jr} from the MIPS opcode/funct rules
  function automatic logic [2:0] ref_flags(input logic [31:0] ir);
    logic [5:0] op;
    op = ir[31:26];
    ref_flags[2] = (op == 6'd4) || (op == 6'd5);
    ref_flags[1] = (op == 6'd2) || (op == 6'd3);
    ref_flags[0] = (op == 6'd0) && (ir[5:0] == 6'd8);
  endfunction

  function automatic logic [2:0] dut_flags();
    return {out_is_branch, out_is_jump, out_is_jr};
  endfunction

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_ir = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [31:0] rir;
    logic [5:0]  ops [6];
    bit          do_push, do_pop;

    reset = 1'b0;
    idle_inputs();

    // ---- directed table ----
    // test 1: single beq round trip
    add(0, 1, 30'h0, 32'h10220003, 0, 3'd1, 1, 30'h0, 32'h10220003, 3'b100, 1);
    add(0, 0, 30'h0, 32'h0,        1, 3'd0, 0, 30'h0, 32'h0,        3'b000, 1);
    // test 2: fill to full, refused fifth push, ordered drain
    add(0, 1, 30'h1, 32'h08000010, 0, 3'd1, 1, 30'h1, 32'h08000010, 3'b010, 1);
    add(0, 1, 30'h2, 32'h00000000, 0, 3'd2, 1, 30'h1, 32'h08000010, 3'b010, 1);
    add(0, 1, 30'h3, 32'h03E00008, 0, 3'd3, 1, 30'h1, 32'h08000010, 3'b010, 1);
    add(0, 1, 30'h4, 32'h14A0FFFF, 0, 3'd4, 1, 30'h1, 32'h08000010, 3'b010, 0);
    add(0, 1, 30'h5, 32'h00000000, 0, 3'd4, 1, 30'h1, 32'h08000010, 3'b010, 0);
    add(0, 0, 30'h0, 32'h0,        1, 3'd3, 1, 30'h2, 32'h00000000, 3'b000, 1);
    add(0, 0, 30'h0, 32'h0,        1, 3'd2, 1, 30'h3, 32'h03E00008, 3'b001, 1);
    add(0, 0, 30'h0, 32'h0,        1, 3'd1, 1, 30'h4, 32'h14A0FFFF, 3'b100, 1);
    add(0, 0, 30'h0, 32'h0,        1, 3'd0, 0, 30'h0, 32'h0,        3'b000, 1);
    // test 3: streaming push+pop; ir=8 encodes jr
    for (int i = 0; i < 10; i++)
      add(0, 1, 30'(i), 32'(i), 1, 3'd1, 1, 30'(i), 32'(i), (i == 8) ? 3'b001 : 3'b000, 1);
    add(0, 0, 30'h0, 32'h0, 1, 3'd0, 0, 30'h0, 32'h0, 3'b000, 1);
    // test 4: flush with concurrent push and pop
    add(0, 1, 30'h10, 32'h08000000, 0, 3'd1, 1, 30'h10, 32'h08000000, 3'b010, 1);
    add(0, 1, 30'h11, 32'h00000000, 0, 3'd2, 1, 30'h10, 32'h08000000, 3'b010, 1);
    add(0, 1, 30'h12, 32'h00000000, 0, 3'd3, 1, 30'h10, 32'h08000000, 3'b010, 1);
    add(1, 1, 30'h20, 32'h10000000, 1, 3'd0, 0, 30'h0,  32'h0,        3'b000, 1);
    add(0, 1, 30'h21, 32'h10000000, 0, 3'd1, 1, 30'h21, 32'h10000000, 3'b100, 1);
    add(0, 0, 30'h0,  32'h0,        1, 3'd0, 0, 30'h0,  32'h0,        3'b000, 1);
    // test 5: full queue, pop with refused push, then push accepted
    add(0, 1, 30'h30, 32'h0, 0, 3'd1, 1, 30'h30, 32'h0, 3'b000, 1);
    add(0, 1, 30'h31, 32'h0, 0, 3'd2, 1, 30'h30, 32'h0, 3'b000, 1);
    add(0, 1, 30'h32, 32'h0, 0, 3'd3, 1, 30'h30, 32'h0, 3'b000, 1);
    add(0, 1, 30'h33, 32'h0, 0, 3'd4, 1, 30'h30, 32'h0, 3'b000, 0);
    add(0, 1, 30'h34, 32'h0C000000, 1, 3'd3, 1, 30'h31, 32'h0, 3'b000, 1);
    add(0, 1, 30'h34, 32'h0C000000, 0, 3'd4, 1, 30'h31, 32'h0, 3'b000, 0);
    add(0, 0, 30'h0, 32'h0, 1, 3'd3, 1, 30'h32, 32'h0,        3'b000, 1);
    add(0, 0, 30'h0, 32'h0, 1, 3'd2, 1, 30'h33, 32'h0,        3'b000, 1);
    add(0, 0, 30'h0, 32'h0, 1, 3'd1, 1, 30'h34, 32'h0C000000, 3'b010, 1);
    add(0, 0, 30'h0, 32'h0, 1, 3'd0, 0, 30'h0,  32'h0,        3'b000, 1);

    // ---- reset state ----
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_ir", 64'(out_ir), 64'd0);
    chk("rst_flags", 64'(dut_flags()), 64'd0);
    #1 reset = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // ---- apply table ----
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      flush = v.fl; in_valid = v.iv; in_pc = v.pc; in_ir = v.ir; out_ready = v.ordy;
      step();
      chk($sformatf("v%0d_count", k), 64'(count), 64'(v.cnt));
      chk($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'(v.ov));
      chk($sformatf("v%0d_in_ready", k), 64'(in_ready), 64'(v.irdy));
      if (v.ov) begin
        chk($sformatf("v%0d_out_pc", k), 64'(out_pc), 64'(v.opc));
        chk($sformatf("v%0d_out_ir", k), 64'(out_ir), 64'(v.oir));
        chk($sformatf("v%0d_flags", k), 64'(dut_flags()), 64'(v.flg));
      end
    end
    idle_inputs();

    // ---- in_ready held high during a flush cycle ----
    in_valid = 1'b1; in_pc = 30'h40; in_ir = 32'h0;
    step();
    in_pc = 30'h41;
    step();
    flush = 1'b1; in_pc = 30'h42;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    step();
    idle_inputs();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);

    // ---- randomized traffic vs queue model ----
    model_q.delete();
    ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd35};
    for (int c = 0; c < 400; c++) begin
      rir = $urandom;
      rir[31:26] = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 2) == 0) rir[5:0] = 6'd8;
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = (c < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      out_ready = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      in_pc     = 30'($urandom);
      in_ir     = rir;
      #1;
      chk($sformatf("r%0d_in_ready", c), 64'(in_ready), 64'(model_q.size() < 4));
      chk($sformatf("r%0d_out_valid", c), 64'(out_valid), 64'(model_q.size() > 0));
      if (model_q.size() > 0) begin
        chk($sformatf("r%0d_out_pc", c), 64'(out_pc), 64'(model_q[0].pc));
        chk($sformatf("r%0d_out_ir", c), 64'(out_ir), 64'(model_q[0].ir));
        chk($sformatf("r%0d_flags", c), 64'(dut_flags()), 64'(ref_flags(model_q[0].ir)));
      end
      if (flush) begin
        model_q.delete();
      end else begin
        do_push = in_valid && (model_q.size() < 4);
        do_pop  = out_ready && (model_q.size() > 0);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back('{pc: in_pc, ir: in_ir});
      end
      @(posedge clk);
      #1;
      chk($sformatf("r%0d_count", c), 64'(count), 64'(model_q.size()));
    end
    idle_inputs();

    // ---- asynchronous reset mid-cycle ----
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b1; in_pc = 30'h50; in_ir = 32'h08000001;
    step();
    in_pc = 30'h51;
    step();
    idle_inputs();
    chk("pre_arst_count", 64'(count), 64'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_pc", 64'(out_pc), 64'd0);
    chk("arst_out_ir", 64'(out_ir), 64'd0);
    #1 reset = 1'b1;
    step();
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_count_after", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
